// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes,
// opcodes, R-type funct codes and ALU control encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU control mapping; flags functs we do not implement.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  // Pure lookup; unknown functs default to ADD and raise illegal.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore control outputs per state, with
// Zero-gated PCEn in BRANCH and Funct-driven ALUControl in EXEC.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  output logic        PCEn,
  output logic        IorD,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  State,
  output logic        Halted,
  output logic        Retire,
  output logic [15:0] InstrCount
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [3:0]  fn_alu;
  logic        fn_bad;
  logic        instr_bad;

  mips_alu_decoder u_alu_dec (
    .funct    (Funct),
    .alu_ctrl (fn_alu),
    .illegal  (fn_bad)
  );

  // Unsupported opcode, or R-type with a funct we do not execute.
  always_comb begin
    instr_bad = 1'b0;
    case (Opcode)
      OP_RTYPE: instr_bad = fn_bad;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_bad = 1'b0;
      default:  instr_bad = 1'b1;
    endcase
  end

  // Next-state and control outputs; everything idles at 0.
  always_comb begin
    state_d    = state_q;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 4'b0000;
    Retire     = 1'b0;
    case (state_q)
      S_IDLE: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1; PCEn = 1'b1; ALUSrcB = 2'b01; ALUControl = ALU_ADD;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11; ALUControl = ALU_ADD;
        if (instr_bad) begin
          // Illegal instructions either stop the machine or retire as NOP.
          if (HALT_ON_ILLEGAL) state_d = S_HALT;
          else begin
            state_d = S_FETCH;
            Retire  = 1'b1;
          end
        end else begin
          case (Opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            default:      state_d = S_JUMP;
          endcase
        end
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = ALU_ADD;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1; ALUControl = ALU_ADD;
        state_d = S_MEMWB;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1; ALUControl = fn_alu;
        state_d = S_ALUWB;
      end
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        ALUControl = ALU_ADD;
        Retire     = 1'b1;
        state_d    = Run ? S_FETCH : S_IDLE;
        case (state_q)
          S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
          S_MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; end
          S_ALUWB:  begin RegWrite = 1'b1; RegDst = 1'b1; end
          S_ADDIWB: RegWrite = 1'b1;
          S_JUMP:   begin PCSrc = 2'b10; PCEn = 1'b1; end
          default: begin
            ALUSrcA = 1'b1; ALUControl = ALU_SUB; PCSrc = 2'b01; PCEn = Zero;
          end
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and retired-instruction counter; reset abandons any instruction.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (Retire) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    State      = state_q;
    Halted     = (state_q == S_HALT);
    InstrCount = cnt_q;
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control; expectations queued, then checked after each edge.
module tb_mips_mc_control;

  logic       Clk, Reset_n, Run, Zero;
  logic [5:0] Opcode, Funct;
  wire [15:0] ctl0, ctl1, cnt0, cnt1;
  wire [3:0]  st0, st1;
  wire        hlt0, hlt1, ret0, ret1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          inst;
    string       tag;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ret;
    logic [15:0] cnt;
    logic        hlt;
  } exp_t;
  exp_t sb[$];

  // Control word: PCEn IorD IRWrite MemWrite RegWrite RegDst MemtoReg ALUSrcA ALUSrcB PCSrc ALUControl
  localparam logic [15:0] C_ZERO = 16'h0000, C_FETCH = 16'hA042, C_DEC = 16'h00C2,
    C_ADR = 16'h0182, C_MRD = 16'h4002, C_MWR = 16'h5002, C_MWB = 16'h0A02,
    C_AWB = 16'h0C02, C_IWB = 16'h0802, C_JMP = 16'h8022, C_BRZ = 16'h8116,
    C_BRN = 16'h0116, C_SUB = 16'h0106, C_SLT = 16'h0107, C_NOR = 16'h010C;

  mips_mc_control #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(ctl0[15]), .IorD(ctl0[14]), .IRWrite(ctl0[13]), .MemWrite(ctl0[12]),
    .RegWrite(ctl0[11]), .RegDst(ctl0[10]), .MemtoReg(ctl0[9]), .ALUSrcA(ctl0[8]),
    .ALUSrcB(ctl0[7:6]), .PCSrc(ctl0[5:4]), .ALUControl(ctl0[3:0]),
    .State(st0), .Halted(hlt0), .Retire(ret0), .InstrCount(cnt0));

  mips_mc_control #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(ctl1[15]), .IorD(ctl1[14]), .IRWrite(ctl1[13]), .MemWrite(ctl1[12]),
    .RegWrite(ctl1[11]), .RegDst(ctl1[10]), .MemtoReg(ctl1[9]), .ALUSrcA(ctl1[8]),
    .ALUSrcB(ctl1[7:6]), .PCSrc(ctl1[5:4]), .ALUControl(ctl1[3:0]),
    .State(st1), .Halted(hlt1), .Retire(ret1), .InstrCount(cnt1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic expect_(input int inst, input string tag, input logic [3:0] st,
                         input logic [15:0] ctl, input logic ret, input logic [15:0] cnt,
                         input logic hlt);
    exp_t e;
    e.inst = inst; e.tag = tag; e.st = st; e.ctl = ctl; e.ret = ret; e.cnt = cnt; e.hlt = hlt;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [3:0] s; logic [15:0] c, n; logic r, h;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin s = st0; c = ctl0; n = cnt0; r = ret0; h = hlt0; end
      else             begin s = st1; c = ctl1; n = cnt1; r = ret1; h = hlt1; end
      vectors++;
      assert (s === e.st && c === e.ctl && r === e.ret && n === e.cnt && h === e.hlt)
      else begin
        miscompares++;
        $error("FAIL %s: got state=%0d ctl=%h retire=%b count=%h halted=%b, want state=%0d ctl=%h retire=%b count=%h halted=%b",
               e.tag, s, c, r, n, h, e.st, e.ctl, e.ret, e.cnt, e.hlt);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // One cycle on the main instance: queue expectation, advance, compare.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] ctl,
                     input logic ret, input logic [15:0] cnt);
    expect_(0, tag, st, ctl, ret, cnt, 1'b0);
    tick();
    chk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Run = 1'b1; Zero = 1'b0; Opcode = 6'b000000; Funct = 6'b100010;
    repeat (2) @(posedge Clk);
    #1;
    expect_(0, "reset", 4'd0, C_ZERO, 1'b0, 16'h0, 1'b0);
    expect_(1, "reset_nop", 4'd0, C_ZERO, 1'b0, 16'h0, 1'b0);
    chk();
    @(negedge Clk) Reset_n = 1'b1;
    cyc("rel_fetch", 4'd1, C_FETCH, 1'b0, 16'd0);

    // R-type sub
    cyc("sub_dec", 4'd2, C_DEC, 1'b0, 16'd0);
    cyc("sub_exec", 4'd7, C_SUB, 1'b0, 16'd0);
    cyc("sub_wb", 4'd8, C_AWB, 1'b1, 16'd0);
    Opcode = 6'b100011;
    cyc("lw_fetch", 4'd1, C_FETCH, 1'b0, 16'd1);
    cyc("lw_dec", 4'd2, C_DEC, 1'b0, 16'd1);
    cyc("lw_adr", 4'd3, C_ADR, 1'b0, 16'd1);
    cyc("lw_rd", 4'd4, C_MRD, 1'b0, 16'd1);
    cyc("lw_wb", 4'd5, C_MWB, 1'b1, 16'd1);
    Opcode = 6'b101011;
    cyc("sw_fetch", 4'd1, C_FETCH, 1'b0, 16'd2);
    cyc("sw_dec", 4'd2, C_DEC, 1'b0, 16'd2);
    cyc("sw_adr", 4'd3, C_ADR, 1'b0, 16'd2);
    cyc("sw_wr", 4'd6, C_MWR, 1'b1, 16'd2);
    Opcode = 6'b000100; Zero = 1'b1;
    cyc("beq1_fetch", 4'd1, C_FETCH, 1'b0, 16'd3);
    cyc("beq1_dec", 4'd2, C_DEC, 1'b0, 16'd3);
    cyc("beq1_br", 4'd9, C_BRZ, 1'b1, 16'd3);
    Zero = 1'b0; #1;
    expect_(0, "beq_zero_drop", 4'd9, C_BRN, 1'b1, 16'd3, 1'b0);
    chk();
    cyc("beq0_fetch", 4'd1, C_FETCH, 1'b0, 16'd4);
    cyc("beq0_dec", 4'd2, C_DEC, 1'b0, 16'd4);
    cyc("beq0_br", 4'd9, C_BRN, 1'b1, 16'd4);
    Opcode = 6'b001000;
    cyc("addi_fetch", 4'd1, C_FETCH, 1'b0, 16'd5);
    cyc("addi_dec", 4'd2, C_DEC, 1'b0, 16'd5);
    cyc("addi_ex", 4'd10, C_ADR, 1'b0, 16'd5);
    cyc("addi_wb", 4'd11, C_IWB, 1'b1, 16'd5);
    Opcode = 6'b000010;
    cyc("j_fetch", 4'd1, C_FETCH, 1'b0, 16'd6);
    cyc("j_dec", 4'd2, C_DEC, 1'b0, 16'd6);
    cyc("j_jump", 4'd12, C_JMP, 1'b1, 16'd6);
    Opcode = 6'b000000; Funct = 6'b101010;
    cyc("slt_fetch", 4'd1, C_FETCH, 1'b0, 16'd7);
    cyc("slt_dec", 4'd2, C_DEC, 1'b0, 16'd7);
    cyc("slt_exec", 4'd7, C_SLT, 1'b0, 16'd7);
    cyc("slt_wb", 4'd8, C_AWB, 1'b1, 16'd7);
    cyc("nor_fetch", 4'd1, C_FETCH, 1'b0, 16'd8);

    // Preload the counter to its top value, then drop Run mid-instruction.
    force u_dut.cnt_q = 16'hFFFF;
    #1 release u_dut.cnt_q;
    Funct = 6'b100111;
    cyc("nor_dec", 4'd2, C_DEC, 1'b0, 16'hFFFF);
    cyc("nor_exec", 4'd7, C_NOR, 1'b0, 16'hFFFF);
    Run = 1'b0;
    cyc("nor_wb", 4'd8, C_AWB, 1'b1, 16'hFFFF);
    cyc("idle_wrap", 4'd0, C_ZERO, 1'b0, 16'h0000);
    cyc("idle_hold", 4'd0, C_ZERO, 1'b0, 16'h0000);

    // Asynchronous reset during DECODE abandons the instruction.
    Run = 1'b1; Opcode = 6'b000010;
    cyc("abort_fetch", 4'd1, C_FETCH, 1'b0, 16'd0);
    cyc("abort_dec", 4'd2, C_DEC, 1'b0, 16'd0);
    #2 Reset_n = 1'b0;
    #1;
    expect_(0, "async_rst", 4'd0, C_ZERO, 1'b0, 16'd0, 1'b0);
    expect_(1, "async_rst_nop", 4'd0, C_ZERO, 1'b0, 16'd0, 1'b0);
    chk();
    @(negedge Clk) Reset_n = 1'b1;
    Opcode = 6'b111111;
    expect_(0, "ill_fetch", 4'd1, C_FETCH, 1'b0, 16'd0, 1'b0);
    expect_(1, "ill_fetch_nop", 4'd1, C_FETCH, 1'b0, 16'd0, 1'b0);
    tick(); chk();
    expect_(0, "ill_dec", 4'd2, C_DEC, 1'b0, 16'd0, 1'b0);
    expect_(1, "ill_dec_nop", 4'd2, C_DEC, 1'b1, 16'd0, 1'b0);
    tick(); chk();
    expect_(0, "ill_halt", 4'd13, C_ZERO, 1'b0, 16'd0, 1'b1);
    expect_(1, "ill_refetch_nop", 4'd1, C_FETCH, 1'b0, 16'd1, 1'b0);
    tick(); chk();
    for (int i = 0; i < 4; i++) begin
      Run = i[0];
      expect_(0, "halt_hold", 4'd13, C_ZERO, 1'b0, 16'd0, 1'b1);
      tick(); chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
